fsm_rx_frame: RTL and testbench

FSM_RX_FRAME -- requirements
Module: fsm_rx_frame

---
 rtl/fsm_rx_frame_if.sv | 39 +++
 rtl/fsm_rx_frame.sv | 226 ++++++++++++++++++++++
 tb/tb_fsm_rx_frame.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_rx_frame_if.sv
// Receive-frame FSM port bundle: line-timing strobes and config in, frame results out.
// Latency: none, wiring only.
// Backpressure: none; every result is a pulse or a held level.
interface fsm_rx_frame_if #(
    parameter int MAX_DATA_BITS = 9,
    parameter int WDT_WIDTH     = 16
);
    logic                     p_Enable_i;
    logic                     Rx_Synch_i;
    logic                     Bit_Synch_i;
    logic                     BitValue_i;
    logic [3:0]               DataBits_i;
    logic [2:0]               ParityMode_i;
    logic                     StopBits_i;
    logic [WDT_WIDTH-1:0]     WdtLimit_i;
    logic [4:0]               State_o;
    logic [3:0]               BitCounter_o;
    logic [MAX_DATA_BITS-1:0] Data_o;
    logic                     DataValid_o;
    logic                     ParityErr_o;
    logic                     FrameErr_o;
    logic                     Timeout_o;

    // Line front-end side: drives strobes and config, observes results.
    modport master (
        output p_Enable_i, Rx_Synch_i, Bit_Synch_i, BitValue_i,
        output DataBits_i, ParityMode_i, StopBits_i, WdtLimit_i,
        input  State_o, BitCounter_o, Data_o, DataValid_o,
        input  ParityErr_o, FrameErr_o, Timeout_o
    );

    // Frame FSM side.
    modport slave (
        input  p_Enable_i, Rx_Synch_i, Bit_Synch_i, BitValue_i,
        input  DataBits_i, ParityMode_i, StopBits_i, WdtLimit_i,
        output State_o, BitCounter_o, Data_o, DataValid_o,
        output ParityErr_o, FrameErr_o, Timeout_o
    );
endinterface

// File: rtl/fsm_rx_frame.sv
// UART-style receive frame FSM: start, data (LSB first), optional parity, 1-2 stops, with watchdog and optional TMR.
// Latency: DataValid_o one cycle after the final stop Bit_Synch_i; Timeout_o while the watchdog equals its limit.
// Backpressure: none; results are one-cycle pulses with data/flags held until the next frame completes.
module fsm_rx_frame #(
    parameter int MAX_DATA_BITS = 9,
    parameter int WDT_WIDTH     = 16,
    parameter int TMR_EN        = 1
) (
    input  logic          clk,
    input  logic          rst,
    fsm_rx_frame_if.slave bus
);
    localparam logic [4:0] S_INTERVAL  = 5'b00001;
    localparam logic [4:0] S_STARTBIT  = 5'b00010;
    localparam logic [4:0] S_DATABITS  = 5'b00100;
    localparam logic [4:0] S_PARITYBIT = 5'b01000;
    localparam logic [4:0] S_STOPBIT   = 5'b10000;
    localparam logic [3:0] LEN_MIN     = 4'd5;
    localparam logic [3:0] LEN_MAX     = 4'(MAX_DATA_BITS);
    localparam logic       TMR         = (TMR_EN != 0);

    // Redundant copies; copies 1/2 are held at zero (and optimised away) when TMR is off.
    logic [4:0]           r_state0, r_state1, r_state2;
    logic [3:0]           r_bitcnt0, r_bitcnt1, r_bitcnt2;
    logic [WDT_WIDTH-1:0] r_wdt0, r_wdt1, r_wdt2;

    logic [4:0]           w_state, w_state_nxt;
    logic [3:0]           w_bitcnt, w_bitcnt_nxt;
    logic [WDT_WIDTH-1:0] w_wdt, w_wdt_nxt;

    // Per-frame latched configuration and accumulation.
    logic [3:0]               r_len;
    logic [2:0]               r_par;
    logic                     r_stop, r_stopcnt;
    logic [MAX_DATA_BITS-1:0] r_shift, r_data;
    logic                     r_acc, r_perr_int, r_ferr_int;
    logic                     r_dvalid, r_perr, r_ferr;

    logic       w_legal, w_par_none, w_tmo_hit, w_final_stop, w_par_exp;
    logic [3:0] w_len_in;
    logic       w_start, w_data_bit, w_par_chk, w_stop_bit, w_complete, w_early, w_timeout;

    assign w_state  = TMR ? ((r_state0 & r_state1) | (r_state0 & r_state2) | (r_state1 & r_state2)) : r_state0;
    assign w_bitcnt = TMR ? ((r_bitcnt0 & r_bitcnt1) | (r_bitcnt0 & r_bitcnt2) | (r_bitcnt1 & r_bitcnt2)) : r_bitcnt0;
    assign w_wdt    = TMR ? ((r_wdt0 & r_wdt1) | (r_wdt0 & r_wdt2) | (r_wdt1 & r_wdt2)) : r_wdt0;

    assign w_legal      = (w_state == S_INTERVAL) || (w_state == S_STARTBIT) || (w_state == S_DATABITS) ||
                          (w_state == S_PARITYBIT) || (w_state == S_STOPBIT);
    assign w_par_none   = (r_par == 3'd0) || (r_par > 3'd4);
    assign w_tmo_hit    = (bus.WdtLimit_i != '0) && (w_wdt == bus.WdtLimit_i) && (w_state != S_INTERVAL);
    assign w_final_stop = (r_stopcnt == r_stop);

    // Clamp the requested data length into the supported range.
    always_comb begin
        w_len_in = bus.DataBits_i;
        if (bus.DataBits_i < LEN_MIN)      w_len_in = LEN_MIN;
        else if (bus.DataBits_i > LEN_MAX) w_len_in = LEN_MAX;
    end

    // Expected parity bit for the latched mode (mark/space are fixed levels).
    always_comb begin
        case (r_par)
            3'd1:    w_par_exp = r_acc;
            3'd2:    w_par_exp = ~r_acc;
            3'd3:    w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    // State register: every copy reloads from the value derived from the voted state, which scrubs upsets.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state0  <= S_INTERVAL;
            r_state1  <= TMR ? S_INTERVAL : '0;
            r_state2  <= TMR ? S_INTERVAL : '0;
            r_bitcnt0 <= '0;
            r_bitcnt1 <= '0;
            r_bitcnt2 <= '0;
            r_wdt0    <= '0;
            r_wdt1    <= '0;
            r_wdt2    <= '0;
        end else begin
            r_state0  <= w_state_nxt;
            r_state1  <= TMR ? w_state_nxt : '0;
            r_state2  <= TMR ? w_state_nxt : '0;
            r_bitcnt0 <= w_bitcnt_nxt;
            r_bitcnt1 <= TMR ? w_bitcnt_nxt : '0;
            r_bitcnt2 <= TMR ? w_bitcnt_nxt : '0;
            r_wdt0    <= w_wdt_nxt;
            r_wdt1    <= TMR ? w_wdt_nxt : '0;
            r_wdt2    <= TMR ? w_wdt_nxt : '0;
        end
    end

    // Next-state, bit counter, watchdog and per-cycle datapath events; disable and bad state win, then timeout.
    always_comb begin
        w_state_nxt  = w_state;
        w_bitcnt_nxt = w_bitcnt;
        w_start      = 1'b0;
        w_data_bit   = 1'b0;
        w_par_chk    = 1'b0;
        w_stop_bit   = 1'b0;
        w_complete   = 1'b0;
        w_early      = 1'b0;
        w_timeout    = 1'b0;
        if (!bus.p_Enable_i || !w_legal) begin
            w_state_nxt  = S_INTERVAL;
            w_bitcnt_nxt = '0;
        end else if (w_tmo_hit) begin
            w_state_nxt  = S_INTERVAL;
            w_bitcnt_nxt = '0;
            w_timeout    = 1'b1;
        end else begin
            case (w_state)
                S_INTERVAL: begin
                    if (bus.Rx_Synch_i) begin
                        w_state_nxt = S_STARTBIT;
                        w_start     = 1'b1;
                    end
                end
                S_STARTBIT: begin
                    if (bus.Bit_Synch_i) begin
                        w_state_nxt  = bus.BitValue_i ? S_INTERVAL : S_DATABITS;
                        w_bitcnt_nxt = '0;
                    end
                end
                S_DATABITS: begin
                    if (bus.Bit_Synch_i) begin
                        w_data_bit = 1'b1;
                        if (w_bitcnt == (r_len - 4'd1)) begin
                            w_bitcnt_nxt = '0;
                            w_state_nxt  = w_par_none ? S_STOPBIT : S_PARITYBIT;
                        end else begin
                            w_bitcnt_nxt = w_bitcnt + 4'd1;
                        end
                    end
                end
                S_PARITYBIT: begin
                    if (bus.Bit_Synch_i) begin
                        w_par_chk   = 1'b1;
                        w_state_nxt = S_STOPBIT;
                    end
                end
                S_STOPBIT: begin
                    if (bus.Bit_Synch_i && w_final_stop) begin
                        // A start edge coinciding with the last stop bit still completes normally.
                        w_stop_bit  = 1'b1;
                        w_complete  = 1'b1;
                        w_start     = bus.Rx_Synch_i;
                        w_state_nxt = bus.Rx_Synch_i ? S_STARTBIT : S_INTERVAL;
                    end else if (bus.Rx_Synch_i) begin
                        // New frame cut this one short: deliver it flagged as a framing error.
                        w_early     = 1'b1;
                        w_complete  = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = S_STARTBIT;
                    end else if (bus.Bit_Synch_i) begin
                        w_stop_bit = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = S_INTERVAL;
                    w_bitcnt_nxt = '0;
                end
            endcase
        end
        w_wdt_nxt = (bus.Bit_Synch_i || (w_state_nxt != w_state) || (w_state == S_INTERVAL)) ?
                    '0 : w_wdt + WDT_WIDTH'(1);
    end

    // Frame datapath: shift in data, accumulate parity/frame errors, publish results on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= LEN_MIN;
            r_par      <= '0;
            r_stop     <= 1'b0;
            r_stopcnt  <= 1'b0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
            r_data     <= '0;
            r_dvalid   <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_dvalid <= w_complete;
            if (w_data_bit) begin
                for (int i = 0; i < MAX_DATA_BITS; i++) begin
                    if (4'(i) == w_bitcnt) r_shift[i] <= bus.BitValue_i;
                end
                r_acc <= r_acc ^ bus.BitValue_i;
            end
            if (w_par_chk && (bus.BitValue_i != w_par_exp)) r_perr_int <= 1'b1;
            if (w_stop_bit && !bus.BitValue_i)              r_ferr_int <= 1'b1;
            if (w_stop_bit && !w_final_stop)                r_stopcnt  <= 1'b1;
            if (w_complete) begin
                r_data <= r_shift;
                r_perr <= r_perr_int;
                r_ferr <= r_ferr_int | w_early | (w_stop_bit & ~bus.BitValue_i);
            end
            // Start of frame is last so it overrides the accumulators of a frame completing this cycle.
            if (w_start) begin
                r_len      <= w_len_in;
                r_par      <= bus.ParityMode_i;
                r_stop     <= bus.StopBits_i;
                r_stopcnt  <= 1'b0;
                r_shift    <= '0;
                r_acc      <= 1'b0;
                r_perr_int <= 1'b0;
                r_ferr_int <= 1'b0;
            end
        end
    end

    // Output decode from voted state and result registers.
    always_comb begin
        bus.State_o      = w_state;
        bus.BitCounter_o = (w_state == S_DATABITS) ? w_bitcnt : 4'd0;
        bus.Data_o       = r_data;
        bus.DataValid_o  = r_dvalid;
        bus.ParityErr_o  = r_perr;
        bus.FrameErr_o   = r_ferr;
        bus.Timeout_o    = w_timeout;
    end
endmodule

// File: tb/tb_fsm_rx_frame.sv
// Directed bench for fsm_rx_frame: reset, 8N1/7E2/8O1 frames, early start, watchdog, disable, reset and TMR upset.
// Latency: checks sampled 1 ns after the rising edge.
// Backpressure: not applicable.
module tb_fsm_rx_frame;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   dv_count = 0;
    int   tmo_count = 0;
    int   dv0, tmo0, tmo_at;

    fsm_rx_frame_if #(.MAX_DATA_BITS(9), .WDT_WIDTH(16)) bus ();

    fsm_rx_frame #(.MAX_DATA_BITS(9), .WDT_WIDTH(16), .TMR_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.DataValid_o === 1'b1) dv_count++;
        if (bus.Timeout_o === 1'b1)   tmo_count++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000 ns");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_bit(input logic v);
        bus.Bit_Synch_i = 1'b1;
        bus.BitValue_i  = v;
        @(posedge clk);
        #1;
        bus.Bit_Synch_i = 1'b0;
        bus.BitValue_i  = 1'b0;
    endtask

    task automatic rx_synch();
        bus.Rx_Synch_i = 1'b1;
        @(posedge clk);
        #1;
        bus.Rx_Synch_i = 1'b0;
    endtask

    // Sends seq[0] first; returns 1 ns after the edge that samples the last bit.
    task automatic send_bits(input logic [15:0] seq, input int n);
        for (int k = 0; k < n; k++) begin
            idle(2);
            pulse_bit(seq[k]);
        end
    endtask

    task automatic config_frame(input logic [3:0] len, input logic [2:0] par, input logic stop);
        bus.DataBits_i   = len;
        bus.ParityMode_i = par;
        bus.StopBits_i   = stop;
    endtask

    initial begin
        bus.p_Enable_i  = 1'b1;
        bus.Rx_Synch_i  = 1'b0;
        bus.Bit_Synch_i = 1'b0;
        bus.BitValue_i  = 1'b0;
        bus.WdtLimit_i  = 16'd0;
        config_frame(4'd8, 3'd0, 1'b0);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_state", bus.State_o, 5'b00001);
        chk("rst_bitcnt", bus.BitCounter_o, 4'd0);
        chk("rst_data", bus.Data_o, 9'h000);
        chk("rst_dv", bus.DataValid_o, 1'b0);
        chk("rst_perr", bus.ParityErr_o, 1'b0);
        chk("rst_ferr", bus.FrameErr_o, 1'b0);
        chk("rst_tmo", bus.Timeout_o, 1'b0);

        // 8N1, data 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1
        rx_synch();
        chk("8n1_startbit", bus.State_o, 5'b00010);
        send_bits(16'h000A, 4);
        chk("8n1_mid_state", bus.State_o, 5'b00100);
        chk("8n1_mid_bitcnt", bus.BitCounter_o, 4'd3);
        send_bits(16'h0034, 6);
        chk("8n1_dv", bus.DataValid_o, 1'b1);
        chk("8n1_data", bus.Data_o, 9'h0A5);
        chk("8n1_perr", bus.ParityErr_o, 1'b0);
        chk("8n1_ferr", bus.FrameErr_o, 1'b0);
        chk("8n1_state_done", bus.State_o, 5'b00001);
        idle(1);
        chk("8n1_dv_one_cycle", bus.DataValid_o, 1'b0);
        chk("8n1_data_held", bus.Data_o, 9'h0A5);

        // 7E2, data 0x41 (even parity 0 expected, 1 sent), stops 1,1
        config_frame(4'd7, 3'd1, 1'b1);
        rx_synch();
        send_bits(16'h0382, 10);
        chk("7e2_first_stop_state", bus.State_o, 5'b10000);
        chk("7e2_first_stop_no_dv", bus.DataValid_o, 1'b0);
        send_bits(16'h0001, 1);
        chk("7e2_dv", bus.DataValid_o, 1'b1);
        chk("7e2_data", bus.Data_o, 9'h041);
        chk("7e2_perr", bus.ParityErr_o, 1'b1);
        chk("7e2_ferr", bus.FrameErr_o, 1'b0);

        // Watchdog: limit 100, stall after 3 data bits
        config_frame(4'd8, 3'd0, 1'b0);
        bus.WdtLimit_i = 16'd100;
        idle(2);
        dv0  = dv_count;
        tmo0 = tmo_count;
        rx_synch();
        send_bits(16'h0006, 4);
        tmo_at = 0;
        for (int n = 1; n <= 150; n++) begin
            @(posedge clk);
            #1;
            if (bus.Timeout_o === 1'b1) tmo_at = n;
            if (tmo_at != 0) break;
        end
        chk("wdt_cycle", tmo_at, 100);
        idle(1);
        chk("wdt_state_after", bus.State_o, 5'b00001);
        chk("wdt_pulse_cleared", bus.Timeout_o, 1'b0);
        chk("wdt_pulse_count", tmo_count - tmo0, 1);
        chk("wdt_no_dv", dv_count - dv0, 0);
        chk("wdt_data_retained", bus.Data_o, 9'h041);
        chk("wdt_perr_retained", bus.ParityErr_o, 1'b1);
        bus.WdtLimit_i = 16'd0;

        // 8O1, data 0x00, parity 1 (correct), stop 0
        config_frame(4'd8, 3'd2, 1'b0);
        rx_synch();
        send_bits(16'h0200, 11);
        chk("8o1_dv", bus.DataValid_o, 1'b1);
        chk("8o1_data", bus.Data_o, 9'h000);
        chk("8o1_perr", bus.ParityErr_o, 1'b0);
        chk("8o1_ferr", bus.FrameErr_o, 1'b1);
        chk("8o1_state_done", bus.State_o, 5'b00001);

        // False start, and Bit_Synch ignored in INTERVAL
        idle(2);
        dv0 = dv_count;
        pulse_bit(1'b0);
        chk("interval_ignores_bitsynch", bus.State_o, 5'b00001);
        rx_synch();
        send_bits(16'h0001, 1);
        chk("false_start_state", bus.State_o, 5'b00001);
        idle(3);
        chk("false_start_no_dv", dv_count - dv0, 0);

        // 8N2, data 0x3C, new start edge after the first stop bit
        config_frame(4'd8, 3'd0, 1'b1);
        rx_synch();
        send_bits(16'h0278, 10);
        chk("early_rx_pre_state", bus.State_o, 5'b10000);
        idle(2);
        rx_synch();
        chk("early_rx_dv", bus.DataValid_o, 1'b1);
        chk("early_rx_data", bus.Data_o, 9'h03C);
        chk("early_rx_ferr", bus.FrameErr_o, 1'b1);
        chk("early_rx_perr", bus.ParityErr_o, 1'b0);
        chk("early_rx_next_state", bus.State_o, 5'b00010);

        // Reset mid-frame
        config_frame(4'd8, 3'd0, 1'b0);
        send_bits(16'h0002, 3);
        chk("rst_mid_pre_bitcnt", bus.BitCounter_o, 4'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_state", bus.State_o, 5'b00001);
        chk("rst_mid_bitcnt", bus.BitCounter_o, 4'd0);
        chk("rst_mid_data", bus.Data_o, 9'h000);
        chk("rst_mid_ferr", bus.FrameErr_o, 1'b0);
        send_bits(16'h0000, 1);
        chk("rst_mid_needs_rxsynch", bus.State_o, 5'b00001);

        // Enable drop in DATABITS
        dv0  = dv_count;
        tmo0 = tmo_count;
        rx_synch();
        send_bits(16'h0002, 3);
        chk("en_pre_state", bus.State_o, 5'b00100);
        chk("en_pre_bitcnt", bus.BitCounter_o, 4'd2);
        bus.p_Enable_i = 1'b0;
        idle(1);
        chk("en_drop_state", bus.State_o, 5'b00001);
        chk("en_drop_bitcnt", bus.BitCounter_o, 4'd0);
        bus.p_Enable_i = 1'b1;
        idle(3);
        chk("en_drop_no_dv", dv_count - dv0, 0);
        chk("en_drop_no_tmo", tmo_count - tmo0, 0);

        // Single-copy upset on the state register
        rx_synch();
        send_bits(16'h0000, 1);
        force dut.r_state1 = 5'b01000;
        #1;
        chk("tmr_vote_hides_upset", bus.State_o, 5'b00100);
        idle(1);
        chk("tmr_vote_over_edge", bus.State_o, 5'b00100);
        release dut.r_state1;
        idle(1);
        chk("tmr_copy_repaired", dut.r_state1, 5'b00100);
        chk("tmr_state_after", bus.State_o, 5'b00100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
